// File: rtl/fifo_param_if.sv
// Producer/consumer-side bundle for fifo_param; the FIFO takes the slave modport.
// The err_clr/overflow/underflow signals exist only when FIFO_PARAM_ERR_FLAGS_EN is defined.
interface fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    logic                  flush;
    logic                  wr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CNT_WIDTH-1:0]  level;
`ifdef FIFO_PARAM_ERR_FLAGS_EN
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;
`endif

    modport master (
        output flush, wr, data_in, rd,
`ifdef FIFO_PARAM_ERR_FLAGS_EN
        output err_clr,
        input  overflow, underflow,
`endif
        input  data_out, data_out_valid, empty, full, almost_empty, almost_full, level
    );

    modport slave (
        input  flush, wr, data_in, rd,
`ifdef FIFO_PARAM_ERR_FLAGS_EN
        input  err_clr,
        output overflow, underflow,
`endif
        output data_out, data_out_valid, empty, full, almost_empty, almost_full, level
    );
endinterface

// File: rtl/fifo_param.sv
// Single-clock FIFO, any depth >= 2, registered read data, programmable almost flags, flush.
// Define FIFO_PARAM_ERR_FLAGS_EN to add sticky overflow/underflow flags with err_clr.
module fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input logic         clk,
    input logic         clear_n,
    fifo_param_if.slave bus
);
    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0] CNT_AE   = CNT_WIDTH'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  level_q, level_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_out_valid_q, data_out_valid_d;

    logic empty, full, wr_acc, rd_acc;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (level_q == '0);
    assign full   = (level_q == CNT_FULL);
    assign wr_acc = bus.wr & ~full & ~bus.flush;
    assign rd_acc = bus.rd & ~empty & ~bus.flush;

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        level_d          = level_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d         = ptr_inc(rd_ptr_q);
                data_out_d       = mem_q[rd_ptr_q];
                data_out_valid_d = 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                level_d = level_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                level_d = level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            level_q          <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            level_q          <= level_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = data_out_valid_q;
    assign bus.level          = level_q;
    assign bus.empty          = empty;
    assign bus.full           = full;
    assign bus.almost_empty   = (level_q <= CNT_AE);
    assign bus.almost_full    = (level_q >= CNT_AF);

`ifdef FIFO_PARAM_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error in the same cycle as err_clr wins.
    always_comb begin
        overflow_d  = (bus.wr & full  & ~bus.flush) | (overflow_q  & ~bus.err_clr & ~bus.flush);
        underflow_d = (bus.rd & empty & ~bus.flush) | (underflow_q & ~bus.err_clr & ~bus.flush);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_param.sv
// Drives an 8-deep (AF 6, AE 2) and a 5-deep (default thresholds) fifo_param with identical
// stimulus and checks both against a shift-list reference model.
module tb_fifo_param;
    logic clk;
    logic clear_n;

    fifo_param_if #(.DATA_WIDTH(8), .FIFO_DEPTH(8)) if8 ();
    fifo_param_if #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) if5 ();

    fifo_param #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u_dut8 (
        .clk(clk), .clear_n(clear_n), .bus(if8.slave)
    );
    fifo_param #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) u_dut5 (
        .clk(clk), .clear_n(clear_n), .bus(if5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] obs_lvl   [2];
    logic [7:0] obs_dout  [2];
    logic       obs_dv    [2];
    logic [3:0] obs_flags [2];
    assign obs_lvl[0]   = if8.level;
    assign obs_lvl[1]   = {1'b0, if5.level};
    assign obs_dout[0]  = if8.data_out;
    assign obs_dout[1]  = if5.data_out;
    assign obs_dv[0]    = if8.data_out_valid;
    assign obs_dv[1]    = if5.data_out_valid;
    assign obs_flags[0] = {if8.empty, if8.full, if8.almost_empty, if8.almost_full};
    assign obs_flags[1] = {if5.empty, if5.full, if5.almost_empty, if5.almost_full};
`ifdef FIFO_PARAM_ERR_FLAGS_EN
    logic [1:0] obs_err [2];
    assign obs_err[0] = {if8.overflow, if8.underflow};
    assign obs_err[1] = {if5.overflow, if5.underflow};
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: ordered list of held words, oldest at index 0.
    logic [7:0] mbuf [2][8];
    int         mcnt [2];
    logic [7:0] mdout [2];
    logic       mdv  [2];
    logic       movf [2];
    logic       munf [2];

    function automatic int depth(input int i);
        return (i == 0) ? 8 : 5;
    endfunction
    function automatic int af_lvl(input int i);
        return (i == 0) ? 6 : 4;
    endfunction
    function automatic int ae_lvl(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mdout[i] = 8'h00; mdv[i] = 1'b0; movf[i] = 1'b0; munf[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic w, input logic r, input logic [7:0] d,
                              input logic fl, input logic ec);
        for (int i = 0; i < 2; i++) begin
            bit is_full, is_empty;
            is_full  = (mcnt[i] == depth(i));
            is_empty = (mcnt[i] == 0);
            if (fl) begin
                mcnt[i] = 0; mdv[i] = 1'b0; movf[i] = 1'b0; munf[i] = 1'b0;
            end else begin
                movf[i] = (w && is_full)  || (movf[i] && !ec);
                munf[i] = (r && is_empty) || (munf[i] && !ec);
                if (r && !is_empty) begin
                    mdout[i] = mbuf[i][0];
                    for (int k = 0; k < 7; k++) mbuf[i][k] = mbuf[i][k+1];
                    mcnt[i]--;
                    mdv[i] = 1'b1;
                end else begin
                    mdv[i] = 1'b0;
                end
                if (w && !is_full) begin
                    mbuf[i][mcnt[i]] = d;
                    mcnt[i]++;
                end
            end
        end
    endtask

    task automatic check(input string tag);
        for (int i = 0; i < 2; i++) begin
            logic [3:0] ef;
            ef = {mcnt[i] == 0, mcnt[i] == depth(i), mcnt[i] <= ae_lvl(i), mcnt[i] >= af_lvl(i)};
            n_tests++;
            assert (obs_lvl[i] === 4'(mcnt[i])) else begin
                n_fail++; $error("FAIL %s.d%0d.level got %0d want %0d", tag, depth(i), obs_lvl[i], mcnt[i]);
            end
            n_tests++;
            assert (obs_flags[i] === ef) else begin
                n_fail++; $error("FAIL %s.d%0d.flags{e,f,ae,af} got %b want %b", tag, depth(i), obs_flags[i], ef);
            end
            n_tests++;
            assert (obs_dv[i] === mdv[i]) else begin
                n_fail++; $error("FAIL %s.d%0d.valid got %b want %b", tag, depth(i), obs_dv[i], mdv[i]);
            end
            n_tests++;
            assert (obs_dout[i] === mdout[i]) else begin
                n_fail++; $error("FAIL %s.d%0d.data_out got %h want %h", tag, depth(i), obs_dout[i], mdout[i]);
            end
`ifdef FIFO_PARAM_ERR_FLAGS_EN
            n_tests++;
            assert (obs_err[i] === {movf[i], munf[i]}) else begin
                n_fail++; $error("FAIL %s.d%0d.{ovf,unf} got %b want %b", tag, depth(i), obs_err[i], {movf[i], munf[i]});
            end
`endif
        end
    endtask

    task automatic expect_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++; $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d,
                         input logic fl, input logic ec);
        if8.wr = w; if8.rd = r; if8.data_in = d; if8.flush = fl;
        if5.wr = w; if5.rd = r; if5.data_in = d; if5.flush = fl;
`ifdef FIFO_PARAM_ERR_FLAGS_EN
        if8.err_clr = ec; if5.err_clr = ec;
`endif
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                       input logic fl, input logic ec, input string tag);
        drive(w, r, d, fl, ec);
        @(posedge clk);
        model_step(w, r, d, fl, ec);
        #1;
        check(tag);
    endtask

    initial begin
        logic [7:0] seq [7];
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        clear_n = 1'b0;
        model_reset();
        #12;
        check("reset");
        clear_n = 1'b1;

        // basic flow
        cyc(1, 0, 8'hA1, 0, 0, "wrA1");
        cyc(1, 0, 8'hB2, 0, 0, "wrB2");
        cyc(1, 0, 8'hC3, 0, 0, "wrC3");
        expect_val("basic.level3", {4'h0, obs_lvl[0]}, 8'd3);
        cyc(0, 1, 8'h00, 0, 0, "rd1");
        expect_val("basic.dout1", obs_dout[0], 8'hA1);
        cyc(0, 1, 8'h00, 0, 0, "rd2");
        expect_val("basic.dout2", obs_dout[0], 8'hB2);
        cyc(0, 1, 8'h00, 0, 0, "rd3");
        expect_val("basic.dout3", obs_dout[1], 8'hC3);
        expect_val("basic.empty", {7'h0, obs_flags[0][3]}, 8'd1);
        cyc(0, 0, 8'h00, 0, 0, "idle");

        // non-power-of-two wrap on the 5-deep instance
        for (int k = 0; k < 5; k++) cyc(1, 0, seq[k], 0, 0, "wrap.fill");
        expect_val("wrap.d5.full", {7'h0, obs_flags[1][2]}, 8'd1);
        cyc(1, 0, 8'hFF, 0, 0, "wrap.drop");
        cyc(0, 1, 8'h00, 0, 0, "wrap.rd");
        cyc(0, 1, 8'h00, 0, 0, "wrap.rd");
        cyc(1, 0, 8'h06, 0, 0, "wrap.wr6");
        cyc(1, 0, 8'h07, 0, 0, "wrap.wr7");
        for (int k = 0; k < 5; k++) cyc(0, 1, 8'h00, 0, 0, "wrap.drain");
        expect_val("wrap.d5.last", obs_dout[1], 8'h07);

        // simultaneous wr+rd while full, then while empty
        cyc(0, 0, 8'h00, 1, 0, "flush");
        for (int k = 0; k < 8; k++) cyc(1, 0, 8'h10 + 8'(k), 0, 0, "sim.fill");
        cyc(1, 1, 8'hEE, 0, 0, "sim.full_wr_rd");
        expect_val("sim.d8.level7", {4'h0, obs_lvl[0]}, 8'd7);
        cyc(0, 0, 8'h00, 1, 0, "flush");
        cyc(1, 1, 8'h5A, 0, 0, "sim.empty_wr_rd");
        expect_val("sim.empty.valid0", {7'h0, obs_dv[0]}, 8'd0);
        cyc(0, 1, 8'h00, 0, 0, "sim.rd5A");
        expect_val("sim.dout5A", obs_dout[0], 8'h5A);

        // thresholds, one word at a time
        cyc(0, 0, 8'h00, 1, 0, "flush");
        for (int k = 0; k < 8; k++) cyc(1, 0, 8'h20 + 8'(k), 0, 0, "thresh.fill");

        // flush beats a simultaneous write
        cyc(0, 0, 8'h00, 1, 0, "flush");
        for (int k = 0; k < 4; k++) cyc(1, 0, 8'h30 + 8'(k), 0, 0, "fl.fill4");
        cyc(1, 0, 8'h99, 1, 0, "fl.flush_wr");
        expect_val("fl.level0", {4'h0, obs_lvl[0]}, 8'd0);
        cyc(0, 1, 8'h00, 0, 0, "fl.rd_empty");

        // async reset mid-cycle
        for (int k = 0; k < 3; k++) cyc(1, 0, 8'h40 + 8'(k), 0, 0, "ar.fill3");
        cyc(0, 1, 8'h00, 0, 0, "ar.rd");
        drive(0, 0, 8'h00, 0, 0);
        #3;
        clear_n = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        expect_val("ar.level0", {4'h0, obs_lvl[0]}, 8'd0);
        #2;
        clear_n = 1'b1;

        // error flags (compared only when the feature is built)
        cyc(0, 1, 8'h00, 0, 0, "err.rd_empty");
        cyc(1, 0, 8'h50, 0, 0, "err.traffic");
        cyc(1, 1, 8'h51, 0, 0, "err.traffic");
        for (int k = 0; k < 9; k++) cyc(1, 0, 8'h60 + 8'(k), 0, 0, "err.overfill");
        cyc(0, 0, 8'h00, 0, 1, "err.clr");
        cyc(0, 0, 8'h00, 0, 0, "err.idle");

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic w, r, fl, ec;
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 50);
            fl = ($urandom_range(0, 39) == 0);
            ec = ($urandom_range(0, 15) == 0);
            cyc(w, r, 8'($urandom), fl, ec, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Second-generation synchronous FIFO: single clock, arbitrary (non-power-of-two) depth, parametrised data width.
- Adds programmable almost-full/almost-empty thresholds, an occupancy output, a synchronous flush, and an asynchronous active-low reset.
- Drop-in successor for the existing 8x8 FIFO in datapath buffering between producer and consumer blocks.
- Read data is registered; one-cycle read latency is kept.

Parameters:
- DATA_WIDTH, 8: data word width in bits, >=1.
- FIFO_DEPTH, 8: number of entries, >=2, need not be a power of two.
- AF_LEVEL, FIFO_DEPTH-1: almost_full asserts when level >= AF_LEVEL; range 1..FIFO_DEPTH.
- AE_LEVEL, 1: almost_empty asserts when level <= AE_LEVEL; range 0..FIFO_DEPTH-1.
- Derived localparams (not overridable): PTR_WIDTH = $clog2(FIFO_DEPTH); CNT_WIDTH = $clog2(FIFO_DEPTH+1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- clear_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous empty request; active high.
- wr  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd  in  1  read request.
- data_out  out  DATA_WIDTH  read data, registered.
- data_out_valid  out  1  data_out holds a word popped last cycle.
- empty  out  1  level == 0.
- full  out  1  level == FIFO_DEPTH.
- almost_empty  out  1  level <= AE_LEVEL.
- almost_full  out  1  level >= AF_LEVEL.
- level  out  CNT_WIDTH  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (clear_n low, asynchronous, any time):
  - wr_ptr = rd_ptr = level = 0.
  - data_out = 0, data_out_valid = 0.
  - Flags follow level: empty = 1, almost_empty = 1, full = 0. almost_full = 0 unless AF_LEVEL would be met at level 0, which cannot happen since AF_LEVEL >= 1.
  - Memory contents are not reset.
  - Deassertion is used as-is; a synchronizer upstream is the integrator's responsibility.
- Flush (posedge with flush = 1) has priority over wr and rd:
  - Pointers and level go to 0; data_out_valid goes to 0; data_out holds.
  - No memory write occurs that cycle.
- Write acceptance: wr_acc = wr & ~full & ~flush.
  - On acceptance, mem[wr_ptr] <= data_in.
  - wr_ptr increments and wraps from FIFO_DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- Read acceptance: rd_acc = rd & ~empty & ~flush.
  - On acceptance, data_out <= mem[rd_ptr] and data_out_valid <= 1 next cycle.
  - rd_ptr increments with the same wrap rule.
  - Without rd_acc, data_out_valid <= 0 and data_out holds its last value (never X).
- Latency:
  - Read: data appears the cycle after rd_acc.
  - Write to read: a word written at cycle N is readable with rd at N+1 (empty deasserts at N+1).
- Level update: +1 if wr_acc & ~rd_acc; -1 if rd_acc & ~wr_acc; unchanged otherwise.
- Simultaneous events:
  - wr & rd while full: read accepted, write rejected; level = FIFO_DEPTH-1.
  - wr & rd while empty: write accepted, read rejected; level = 1, data_out_valid = 0.
  - wr & rd otherwise: both accepted, level unchanged.
  - Rejected requests are dropped silently, with no stall or retry.
- Flags are combinational from registered level only; there is no combinational path from wr/rd to any output.

Optional Feature:
- Macro: FIFO_PARAM_ERR_FLAGS_EN.
- Defined:
  - Adds outputs overflow and underflow (1 bit each) and input err_clr (1 bit).
  - overflow sets on posedge when wr & full & ~flush. underflow sets on posedge when rd & empty & ~flush.
  - Both flags are sticky until err_clr = 1 or flush = 1 (cleared next edge) or clear_n low (cleared asynchronously).
  - A set condition and err_clr in the same cycle leave the flag at 1.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Reset and basic flow: reset, then write 0xA1, 0xB2, 0xC3 on consecutive cycles, then rd for 3 cycles -> data_out = 0xA1, 0xB2, 0xC3 each one cycle after rd, valid high for 3 cycles, level 3->0, empty = 1 at end.
- Non-power-of-two wrap, FIFO_DEPTH = 5: write 5 words (0x01..0x05) -> full = 1, level = 5. Sixth write of 0xFF is dropped. Read 2, write 0x06 and 0x07, read 5 -> order 0x01..0x07, with no 0xFF.
- Simultaneous operations:
  - When full, drive wr = rd = 1 -> level = FIFO_DEPTH-1, write dropped.
  - When empty, drive wr = rd = 1 with 0x5A -> level = 1, valid = 0; next-cycle rd returns 0x5A.
- Thresholds, AF_LEVEL = 6, AE_LEVEL = 2, FIFO_DEPTH = 8: fill one word at a time -> almost_empty high for level 0..2, almost_full high from level 6.
- Flush and async reset:
  - At level 4, pulse flush together with wr -> next cycle level = 0, empty = 1, no write.
  - Refill to 3, assert clear_n low mid-cycle -> outputs reset immediately, without waiting for a clock edge.
- With FIFO_PARAM_ERR_FLAGS_EN defined:
  - rd on empty -> underflow = 1 and stays 1 through later traffic.
  - wr on full -> overflow = 1.
  - err_clr pulse -> both flags 0 next cycle.
